// File: rtl/branch_redirect_unit.sv
// ---------------------------------------------------------------------------
// branch_redirect_unit
//
// Purpose:
//   Execute-stage branch/jump resolver for an RV32I pipeline. Evaluates the
//   branch condition and the jump target. Drives the fetch PC mux through
//   pcJump / pcIncrementOrJump and squashes the IF/ID and ID/EX registers
//   when a redirect is applied. If fetch is stalled when a redirect resolves,
//   the target is held in pendingTarget until fetch can accept it. Applied
//   redirects are counted for performance monitoring.
//
// Parameters:
//   ALIGN_CHECK  1: a taken target with bits[1:0] != 0 is suppressed and
//                   flagged on misalignedTarget. 0: the target is passed on.
//   COUNT_W      width of redirectCount. The counter wraps around.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   exValid             EX stage holds a valid instruction
//   exBranch/exJal/
//   exJalr              instruction type (priority JALR > JAL > branch)
//   exFunct3            branch condition code
//   exPc, exImm         PC and sign-extended immediate of the EX instruction
//   exRs1Data/exRs2Data forwarded register operands
//   fetchStall          PC register does not load this cycle
//   pcJump              redirect target to the PC mux
//   pcIncrementOrJump   1 selects pcJump, 0 selects the sequential PC
//   flushIfId/flushIdEx squash the front-end pipeline registers
//   redirectPending     a stalled redirect is being held
//   misalignedTarget    one-cycle pulse, one cycle after a misaligned target
//   redirectCount       number of applied redirects
// ---------------------------------------------------------------------------
module branch_redirect_unit #(
    parameter int ALIGN_CHECK = 1,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               exValid,
    input  logic               exBranch,
    input  logic               exJal,
    input  logic               exJalr,
    input  logic [2:0]         exFunct3,
    input  logic [31:0]        exPc,
    input  logic [31:0]        exImm,
    input  logic [31:0]        exRs1Data,
    input  logic [31:0]        exRs2Data,
    input  logic               fetchStall,
    output logic [31:0]        pcJump,
    output logic               pcIncrementOrJump,
    output logic               flushIfId,
    output logic               flushIdEx,
    output logic               redirectPending,
    output logic               misalignedTarget,
    output logic [COUNT_W-1:0] redirectCount
);

    localparam bit ALIGN_EN = (ALIGN_CHECK != 0);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_pendingTarget;
    logic [31:0]         w_pendingTarget_nxt;
    logic [COUNT_W-1:0]  r_count;
    logic                r_misaligned;
    logic                w_misaligned_nxt;
    logic                w_apply;

    logic signed [31:0]  w_rs1_s;
    logic signed [31:0]  w_rs2_s;
    logic                w_eq;
    logic                w_lt_s;
    logic                w_lt_u;
    logic                w_cond;
    logic [31:0]         w_sum_pc;
    logic [31:0]         w_sum_rs1;
    logic [31:0]         w_target;
    logic                w_taken;
    logic                w_bad;

    // Branch condition evaluation
    assign w_rs1_s = exRs1Data;
    assign w_rs2_s = exRs2Data;
    assign w_eq    = (exRs1Data == exRs2Data);
    assign w_lt_s  = (w_rs1_s < w_rs2_s);
    assign w_lt_u  = (exRs1Data < exRs2Data);

    always_comb begin
        w_cond = 1'b0;
        case (exFunct3)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = !w_eq;
            3'b100:  w_cond = w_lt_s;
            3'b101:  w_cond = !w_lt_s;
            3'b110:  w_cond = w_lt_u;
            3'b111:  w_cond = !w_lt_u;
            default: w_cond = 1'b0;   // 010/011 are not branch encodings
        endcase
    end

    // Target selection; JALR wins over JAL, which wins over a branch.
    // Both sums wrap modulo 2^32.
    assign w_sum_pc  = exPc + exImm;
    assign w_sum_rs1 = exRs1Data + exImm;
    assign w_target  = exJalr ? (w_sum_rs1 & 32'hFFFF_FFFE) : w_sum_pc;

    assign w_taken = exValid & (exJalr | exJal | (exBranch & w_cond));
    assign w_bad   = ALIGN_EN & (w_target[1:0] != 2'b00);

    // Next-state and redirect outputs
    always_comb begin
        w_state_nxt         = r_state;
        w_pendingTarget_nxt = r_pendingTarget;
        w_misaligned_nxt    = 1'b0;
        w_apply             = 1'b0;
        pcJump              = 32'h0;
        pcIncrementOrJump   = 1'b0;
        flushIfId           = 1'b0;
        flushIdEx           = 1'b0;
        redirectPending     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_taken && w_bad) begin
                    w_misaligned_nxt = 1'b1;
                end else if (w_taken) begin
                    if (fetchStall) begin
                        w_pendingTarget_nxt = w_target;
                        w_state_nxt         = S_PENDING;
                    end else begin
                        pcJump            = w_target;
                        pcIncrementOrJump = 1'b1;
                        flushIfId         = 1'b1;
                        flushIdEx         = 1'b1;
                        w_apply           = 1'b1;
                    end
                end
            end
            S_PENDING: begin
                // The EX instruction is not evaluated while a redirect is held;
                // the flush applied on release squashes it anyway.
                redirectPending = 1'b1;
                pcJump          = r_pendingTarget;
                if (!fetchStall) begin
                    pcIncrementOrJump = 1'b1;
                    flushIfId         = 1'b1;
                    flushIdEx         = 1'b1;
                    w_apply           = 1'b1;
                    w_state_nxt       = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // The outputs read as zero for the whole time reset is asserted, not
        // only after the registers have cleared.
        if (reset) begin
            pcJump            = 32'h0;
            pcIncrementOrJump = 1'b0;
            flushIfId         = 1'b0;
            flushIdEx         = 1'b0;
            redirectPending   = 1'b0;
            w_apply           = 1'b0;
        end
    end

    // State, held target, misalignment flag and counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_pendingTarget <= 32'h0;
            r_count         <= '0;
            r_misaligned    <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pendingTarget <= w_pendingTarget_nxt;
            r_misaligned    <= w_misaligned_nxt;
            if (w_apply) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign misalignedTarget = r_misaligned & !reset;
    assign redirectCount    = r_count;

endmodule

// File: tb/tb_branch_redirect_unit.sv
module tb_branch_redirect_unit;

    logic        clk;
    logic        reset;
    logic        exValid, exBranch, exJal, exJalr;
    logic [2:0]  exFunct3;
    logic [31:0] exPc, exImm, exRs1Data, exRs2Data;
    logic        fetchStall;

    logic [31:0] pcJump, pcJump2;
    logic        sel, sel2, fIfId, fIfId2, fIdEx, fIdEx2;
    logic        pend, pend2, mis, mis2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int tests_run = 0;
    int tests_failed = 0;

    // Main instance: alignment check on, 16-bit counter
    branch_redirect_unit #(.ALIGN_CHECK(1), .COUNT_W(16)) dut (
        .clk(clk), .reset(reset), .exValid(exValid), .exBranch(exBranch),
        .exJal(exJal), .exJalr(exJalr), .exFunct3(exFunct3), .exPc(exPc),
        .exImm(exImm), .exRs1Data(exRs1Data), .exRs2Data(exRs2Data),
        .fetchStall(fetchStall), .pcJump(pcJump), .pcIncrementOrJump(sel),
        .flushIfId(fIfId), .flushIdEx(fIdEx), .redirectPending(pend),
        .misalignedTarget(mis), .redirectCount(cnt)
    );

    // Second instance: alignment check off, 2-bit counter (wrap behaviour)
    branch_redirect_unit #(.ALIGN_CHECK(0), .COUNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .exValid(exValid), .exBranch(exBranch),
        .exJal(exJal), .exJalr(exJalr), .exFunct3(exFunct3), .exPc(exPc),
        .exImm(exImm), .exRs1Data(exRs1Data), .exRs2Data(exRs2Data),
        .fetchStall(fetchStall), .pcJump(pcJump2), .pcIncrementOrJump(sel2),
        .flushIfId(fIfId2), .flushIdEx(fIdEx2), .redirectPending(pend2),
        .misalignedTarget(mis2), .redirectCount(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, valid, br, jal, jalr;
        logic [2:0]  f3;
        logic [31:0] pc, imm, rs1, rs2;
        logic        stall;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        sel, fif, fex, pend, mis;
        logic [15:0] cnt;
        logic [31:0] pc2;
        logic        sel2, fif2, fex2, pend2, mis2;
        logic [1:0]  cnt2;
    } obs_t;

    obs_t        exp_q[$];
    logic [15:0] exp_cnt  = '0;
    logic [1:0]  exp_cnt2 = '0;

    function automatic stim_t st(input logic rst, input logic valid, input logic br,
                                 input logic jal, input logic jalr, input logic [2:0] f3,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic stall);
        stim_t s;
        s.rst = rst; s.valid = valid; s.br = br; s.jal = jal; s.jalr = jalr;
        s.f3 = f3; s.pc = pc; s.imm = imm; s.rs1 = rs1; s.rs2 = rs2; s.stall = stall;
        return s;
    endfunction

    function automatic stim_t idle(input logic stall);
        return st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, stall);
    endfunction

    // Scoreboard push: builds the expected output of one cycle and advances
    // the bench's own redirect counters when a redirect is expected.
    task automatic push_exp(input logic rst, input logic [31:0] pc, input logic s,
                            input logic p, input logic m, input logic [31:0] pc2,
                            input logic s2, input logic p2);
        obs_t e;
        if (rst) begin
            exp_cnt  = '0;
            exp_cnt2 = '0;
        end
        e.pc = pc; e.sel = s; e.fif = s; e.fex = s; e.pend = p; e.mis = m;
        e.cnt = exp_cnt;
        e.pc2 = pc2; e.sel2 = s2; e.fif2 = s2; e.fex2 = s2; e.pend2 = p2; e.mis2 = 1'b0;
        e.cnt2 = exp_cnt2;
        exp_q.push_back(e);
        if (s)  exp_cnt  = exp_cnt + 16'd1;
        if (s2) exp_cnt2 = exp_cnt2 + 2'd1;
    endtask

    task automatic push_same(input logic [31:0] pc, input logic s, input logic p, input logic m);
        push_exp(1'b0, pc, s, p, m, pc, s, p);
    endtask

    task automatic drive(input stim_t s);
        reset      = s.rst;
        exValid    = s.valid;
        exBranch   = s.br;
        exJal      = s.jal;
        exJalr     = s.jalr;
        exFunct3   = s.f3;
        exPc       = s.pc;
        exImm      = s.imm;
        exRs1Data  = s.rs1;
        exRs2Data  = s.rs2;
        fetchStall = s.stall;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.pc = pcJump; o.sel = sel; o.fif = fIfId; o.fex = fIdEx; o.pend = pend;
        o.mis = mis; o.cnt = cnt;
        o.pc2 = pcJump2; o.sel2 = sel2; o.fif2 = fIfId2; o.fex2 = fIdEx2;
        o.pend2 = pend2; o.mis2 = mis2; o.cnt2 = cnt2;
        return o;
    endfunction

    task automatic test_reset();
        stim_t q[$];
        obs_t  o, e;
        q.push_back(idle(1'b0));                  q[$].rst = 1'b1;
        push_exp(1'b1, 32'h0, 0, 0, 0, 32'h0, 0, 0);
        q.push_back(st(1, 1, 0, 1, 0, 3'd0, 32'h40, 32'h100, 0, 0, 0));
        push_exp(1'b1, 32'h0, 0, 0, 0, 32'h0, 0, 0);
        q.push_back(idle(1'b0));
        push_same(32'h0, 0, 0, 0);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            #4;
            o = sample();
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset[%0d]: got %h, expected %h", i, o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq_and_priority();
        stim_t q[$];
        obs_t  o, e;
        q.push_back(st(0, 1, 1, 0, 0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 0));
        push_same(32'h120, 1, 0, 0);
        q.push_back(idle(1'b0));
        push_same(32'h0, 0, 0, 0);
        // exValid low: every type bit set, still no action
        q.push_back(st(0, 0, 1, 1, 1, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 0));
        push_same(32'h0, 0, 0, 0);
        // JALR beats JAL: rs1+imm, not pc+imm
        q.push_back(st(0, 1, 0, 1, 1, 3'b000, 32'h1000, 32'h8, 32'h500, 32'h0, 0));
        push_same(32'h508, 1, 0, 0);
        // JAL beats an untaken branch
        q.push_back(st(0, 1, 1, 1, 0, 3'b001, 32'h1000, 32'h8, 32'd5, 32'd5, 0));
        push_same(32'h1008, 1, 0, 0);
        q.push_back(st(0, 1, 1, 0, 0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd6, 0));
        push_same(32'h0, 0, 0, 0);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            #4;
            o = sample();
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL beq_priority[%0d]: got %h, expected %h", i, o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_conds();
        typedef struct packed { logic [2:0] f3; logic [31:0] a, b; logic tk; } row_t;
        row_t  tbl[12];
        stim_t q[$];
        obs_t  o, e;
        tbl[0]  = '{3'b000, 32'd5,         32'd5,         1'b1};
        tbl[1]  = '{3'b000, 32'd5,         32'd6,         1'b0};
        tbl[2]  = '{3'b001, 32'd5,         32'd6,         1'b1};
        tbl[3]  = '{3'b100, 32'hFFFF_FFFF, 32'd1,         1'b1};
        tbl[4]  = '{3'b110, 32'hFFFF_FFFF, 32'd1,         1'b0};
        tbl[5]  = '{3'b101, 32'hFFFF_FFFF, 32'd1,         1'b0};
        tbl[6]  = '{3'b111, 32'hFFFF_FFFF, 32'd1,         1'b1};
        tbl[7]  = '{3'b010, 32'd5,         32'd5,         1'b0};
        tbl[8]  = '{3'b011, 32'd5,         32'd6,         1'b0};
        tbl[9]  = '{3'b101, 32'd7,         32'd7,         1'b1};
        tbl[10] = '{3'b110, 32'd1,         32'd2,         1'b1};
        tbl[11] = '{3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        for (int i = 0; i < 12; i++) begin
            q.push_back(st(0, 1, 1, 0, 0, tbl[i].f3, 32'h300, 32'h40, tbl[i].a, tbl[i].b, 0));
            push_same(tbl[i].tk ? 32'h340 : 32'h0, tbl[i].tk, 0, 0);
        end
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            #4;
            o = sample();
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL branch_cond[%0d] f3=%b: got %h, expected %h", i, q[i].f3, o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jalr_misaligned();
        stim_t q[$];
        obs_t  o, e;
        q.push_back(st(0, 1, 0, 0, 1, 3'd0, 32'h0, 32'h4, 32'h2001, 32'h0, 0));
        push_same(32'h2004, 1, 0, 0);
        q.push_back(st(0, 1, 0, 0, 1, 3'd0, 32'h0, 32'h0, 32'h2006, 32'h0, 0));
        push_exp(0, 32'h0, 0, 0, 0, 32'h2006, 1, 0);
        q.push_back(idle(1'b0));
        push_exp(0, 32'h0, 0, 0, 1, 32'h0, 0, 0);
        q.push_back(idle(1'b0));
        push_same(32'h0, 0, 0, 0);
        // Misaligned target while stalled: no hold in the checking instance
        q.push_back(st(0, 1, 1, 0, 0, 3'b000, 32'h100, 32'h2, 32'd9, 32'd9, 1));
        push_same(32'h0, 0, 0, 0);
        q.push_back(idle(1'b0));
        push_exp(0, 32'h0, 0, 0, 1, 32'h102, 1, 1);
        q.push_back(idle(1'b0));
        push_same(32'h0, 0, 0, 0);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            #4;
            o = sample();
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL jalr_misaligned[%0d]: got %h, expected %h", i, o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        stim_t q[$];
        obs_t  o, e;
        q.push_back(st(0, 1, 0, 1, 0, 3'd0, 32'h40, 32'h100, 0, 0, 1));
        push_same(32'h0, 0, 0, 0);
        q.push_back(st(0, 1, 0, 1, 0, 3'd0, 32'h800, 32'h0, 0, 0, 1));
        push_same(32'h140, 0, 1, 0);
        q.push_back(st(0, 1, 0, 0, 1, 3'd0, 32'h0, 32'h0, 32'h2006, 0, 1));
        push_same(32'h140, 0, 1, 0);
        q.push_back(st(0, 1, 0, 1, 0, 3'd0, 32'h800, 32'h0, 0, 0, 0));
        push_same(32'h140, 1, 1, 0);
        q.push_back(idle(1'b0));
        push_same(32'h0, 0, 0, 0);
        q.push_back(idle(1'b1));
        push_same(32'h0, 0, 0, 0);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            #4;
            o = sample();
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL stall[%0d]: got %h, expected %h", i, o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_pending();
        stim_t q[$];
        obs_t  o, e;
        q.push_back(st(0, 1, 0, 1, 0, 3'd0, 32'h40, 32'h100, 0, 0, 1));
        push_same(32'h0, 0, 0, 0);
        q.push_back(idle(1'b1));
        push_same(32'h140, 0, 1, 0);
        q.push_back(idle(1'b1));                  q[$].rst = 1'b1;
        push_exp(1, 32'h0, 0, 0, 0, 32'h0, 0, 0);
        q.push_back(st(0, 1, 1, 0, 0, 3'b001, 32'h100, 32'h20, 32'd3, 32'd3, 0));
        push_same(32'h0, 0, 0, 0);
        q.push_back(idle(1'b0));
        push_same(32'h0, 0, 0, 0);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            #4;
            o = sample();
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset_pending[%0d]: got %h, expected %h", i, o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back_wrap();
        stim_t q[$];
        obs_t  o, e;
        q.push_back(idle(1'b0));                  q[$].rst = 1'b1;
        push_exp(1, 32'h0, 0, 0, 0, 32'h0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            q.push_back(st(0, 1, 1, 0, 0, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'd1, 32'd1, 0));
            push_same(32'h0000_0010, 1, 0, 0);
        end
        q.push_back(idle(1'b0));
        push_same(32'h0, 0, 0, 0);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i]);
            #4;
            o = sample();
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL back_to_back_wrap[%0d]: got %h, expected %h", i, o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        drive(idle(1'b0));
        reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_beq_and_priority();
        test_branch_conds();
        test_jalr_misaligned();
        test_stall();
        test_reset_pending();
        test_back_to_back_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Execute-stage producer of the fetch redirect: resolves RV32I branches and jumps, and drives pcJump and pcIncrementOrJump into the fetch-stage PC input mux.
- Issues flushes to the IF/ID and ID/EX pipeline registers.
- Holds a redirect pending while fetch is stalled, so no taken branch is lost.
- Counts applied redirects for performance monitoring.

Parameters:
- ALIGN_CHECK, 1, when 1 a target with bits[1:0]!=0 is suppressed and flagged; when 0 the target is passed unchanged.
- COUNT_W, 16, width of the redirect performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- exValid  input  1  EX stage holds a valid instruction.
- exBranch  input  1  instruction is a conditional branch.
- exJal  input  1  instruction is JAL.
- exJalr  input  1  instruction is JALR.
- exFunct3  input  3  branch condition code.
- exPc  input  32  PC of the EX instruction.
- exImm  input  32  sign-extended immediate.
- exRs1Data  input  32  forwarded rs1 value.
- exRs2Data  input  32  forwarded rs2 value.
- fetchStall  input  1  PC register will not load this cycle.
- pcJump  output  32  redirect target to the PC mux.
- pcIncrementOrJump  output  1  1 selects pcJump, 0 selects pcIncrement.
- flushIfId  output  1  squash the IF/ID register.
- flushIdEx  output  1  squash the ID/EX register.
- redirectPending  output  1  a stalled redirect is being held.
- misalignedTarget  output  1  one-cycle pulse: a taken target was misaligned.
- redirectCount  output  COUNT_W  number of redirects applied.

Behaviour:
- Condition by exFunct3:
  - 000 BEQ (rs1==rs2); 001 BNE (!=).
  - 100 BLT and 101 BGE, signed.
  - 110 BLTU and 111 BGEU, unsigned.
  - 010 and 011: never taken.
- Type priority when more than one type bit is set: exJalr > exJal > exBranch.
- Target:
  - JAL and branch: exPc+exImm, modulo 2^32 (wrap-around, no overflow flag).
  - JALR: (exRs1Data+exImm) with bit0 forced to 0.
- taken = exValid & (exJalr | exJal | (exBranch & cond)).
- bad = ALIGN_CHECK & (target[1:0]!=0).
- States: IDLE, PENDING. Register pendingTarget[31:0].
- IDLE:
  - taken & !bad & !fetchStall → same-cycle (combinational) apply: pcJump=target, pcIncrementOrJump=1, flushIfId=1, flushIdEx=1, redirectCount+=1. Stay IDLE.
  - taken & !bad & fetchStall → pendingTarget<=target, go PENDING. No select and no flush this cycle.
  - taken & bad → no redirect, no flush. misalignedTarget=1 on the next cycle, for exactly one cycle.
  - otherwise → pcJump=0, pcIncrementOrJump=0, flushes 0.
- PENDING:
  - redirectPending=1. pcJump=pendingTarget. EX inputs are ignored.
  - fetchStall=1 → hold; select=0, flushes 0.
  - fetchStall=0 → apply: select=1, flushes=1, count+=1, go IDLE. The EX instruction presented in this same cycle is not evaluated.
- Counter: wraps from 2^COUNT_W-1 to 0.
- Outputs are combinational from state and registers; there is no extra pipeline latency.
- Reset, asynchronous, any time including mid-PENDING:
  - state=IDLE, pendingTarget=0, redirectCount=0, misaligned register=0.
  - Outputs: pcJump=0, pcIncrementOrJump=0, flushIfId=0, flushIdEx=0, redirectPending=0, misalignedTarget=0.
  - Any held redirect is discarded.
- exValid=0: no action, even if type bits are set.

Test Plan:
- BEQ taken: exPc=0x100, imm=0x20, rs1=rs2=5, valid → same cycle pcJump=0x120, select=1, both flushes=1; count 0→1.
- BLT signed vs BLTU: rs1=0xFFFFFFFF, rs2=1.
  - funct3=100 → taken.
  - funct3=110 → not taken: select=0, flushes 0, pcJump=0.
- JALR: rs1=0x2001, imm=0x4 → pcJump=0x2004 (bit0 cleared), select=1. Target 0x2006 with ALIGN_CHECK=1 → no redirect; misalignedTarget=1 for one cycle, on the next cycle.
- Stalled jump: JAL exPc=0x40, imm=0x100 with fetchStall=1 for 3 cycles.
  - Stall cycles: redirectPending=1, pcJump=0x140, select=0.
  - Cycle stall drops: select=1, flushes=1, count+1, then IDLE.
- Reset during PENDING → all outputs 0 immediately; after release, an untaken instruction gives select=0.
- Wrap: COUNT_W=2, apply 5 taken branches → count sequence 1,2,3,0,1. Target wrap: exPc=0xFFFFFFF0, imm=0x20 → pcJump=0x00000010.
